// File: rtl/timer_tick_master.sv
// -----------------------------------------------------------------------------
// timer_tick_master
//
// Purpose
//   Bus initiator that drives the memory-mapped timer peripheral so that it
//   produces a periodic tick without software involvement.
//     - start : samples the period, arms the timer at now+period, and enters
//               running mode.
//     - while running, each TimerInterrupt is serviced by re-arming the timer
//       at now+period, acknowledging the interrupt, and pulsing tick.
//   The block sits beside the CPU on the data-memory bus and obtains the bus
//   through a req/gnt arbiter.
//
// Optional feature (macro TICK_MASTER_COUNT_EN)
//   When defined, two extra outputs are added:
//     tick_count : free-running count of ticks, wraps, cleared by start.
//     overrun    : sticky flag. It is set when TimerInterrupt is still high
//                  in DONE of an interrupt-triggered sequence, which means
//                  the acknowledge was lost. Cleared by reset or start.
//   When the macro is undefined, neither port nor its logic exists.
//
// Ports
//   clock          in   1      single clock, rising edge
//   reset          in   1      synchronous, active-high
//   start          in   1      pulse: load period, arm timer, enter running mode
//   stop           in   1      pulse: leave running mode once the sequence ends
//   period         in   width  tick period in cycles, sampled on start
//   TimerInterrupt in   1      interrupt line from the timer
//   bus_gnt        in   1      arbiter grant for this master
//   rdata          in   width  bus read data (timer cycle value)
//   bus_req        out  1      bus request
//   address        out  width  bus address
//   data           out  width  bus write data
//   MemRead        out  1      bus read strobe
//   MemWrite       out  1      bus write strobe
//   tick           out  1      one-cycle pulse per serviced interrupt
//   running        out  1      running mode active
//   busy           out  1      a bus sequence is in progress (state != IDLE)
//   tick_count     out  width  (TICK_MASTER_COUNT_EN only) tick counter
//   overrun        out  1      (TICK_MASTER_COUNT_EN only) lost-ACK flag
// -----------------------------------------------------------------------------
module timer_tick_master #(
   parameter int unsigned       width                    = 32,
   parameter logic [width-1:0]  currentTimeAddr          = 32'hFFFF001C,
   parameter logic [width-1:0]  acknowledgeInterruptAddr = 32'hFFFF006C,
   parameter int unsigned       MIN_PERIOD               = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [width-1:0] period,
   input  logic             TimerInterrupt,
   input  logic             bus_gnt,
   input  logic [width-1:0] rdata,
   output logic             bus_req,
   output logic [width-1:0] address,
   output logic [width-1:0] data,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             tick,
   output logic             running,
   output logic             busy
`ifdef TICK_MASTER_COUNT_EN
   ,
   output logic [width-1:0] tick_count,
   output logic             overrun
`endif
);

   // ---------------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------------
   localparam logic [2:0] IDLE = 3'd0;   // waiting for start or an interrupt
   localparam logic [2:0] REQ  = 3'd1;   // requesting the bus
   localparam logic [2:0] RD   = 3'd2;   // reading the current timer value
   localparam logic [2:0] ARM  = 3'd3;   // writing the new deadline
   localparam logic [2:0] ACK  = 3'd4;   // acknowledging the interrupt
   localparam logic [2:0] DONE = 3'd5;   // tick pulse; lets the timer clear its IRQ

   localparam logic [width-1:0] min_period_w = width'(MIN_PERIOD);

   logic [2:0]       state;
   logic             do_ack;     // current sequence was triggered by an interrupt
   logic [width-1:0] period_q;   // clamped period captured on start
   logic [width-1:0] now_q;      // timer value captured in RD
   logic [width-1:0] period_clamped;
   logic             start_accept;
   logic             irq_accept;

   // A period below MIN_PERIOD could yield a deadline that is already in the
   // past when ARM's write lands one cycle after RD sampled the time.
   assign period_clamped = (period < min_period_w) ? min_period_w : period;

   // start is honoured only from IDLE; in any other state it is dropped.
   assign start_accept = (state == IDLE) && start;

   // An interrupt launches a sequence only while running and not being
   // stopped in this very cycle, so nothing new starts once stop is seen.
   assign irq_accept   = (state == IDLE) && !start && running && !stop && TimerInterrupt;

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   // NOTE: every register in clocked blocks is assigned with <= so that all
   // flops update together from values sampled before the edge; blocking
   // assignments here would create order-dependent simulation and mismatch
   // synthesis.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         do_ack   <= 1'b0;
         running  <= 1'b0;
         period_q <= '0;
         now_q    <= '0;
      end else begin
         // stop clears running in any state; an accepted start below is
         // written later in the block and therefore wins in the same cycle.
         if (stop) begin
            running <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_accept) begin
                  state    <= REQ;
                  do_ack   <= 1'b0;
                  running  <= 1'b1;
                  period_q <= period_clamped;
               end else if (irq_accept) begin
                  state  <= REQ;
                  do_ack <= 1'b1;
               end
            end

            REQ: begin
               if (bus_gnt) begin
                  state <= RD;
               end
            end

            // In RD, ARM and ACK a missing grant holds the state so the same
            // bus step is retried once the grant returns.
            RD: begin
               if (bus_gnt) begin
                  now_q <= rdata;
                  state <= ARM;
               end
            end

            ARM: begin
               if (bus_gnt) begin
                  state <= do_ack ? ACK : DONE;
               end
            end

            ACK: begin
               if (bus_gnt) begin
                  state <= DONE;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Bus outputs: purely combinational from state, zero-cycle latency.
   // ---------------------------------------------------------------------------
   // NOTE: every output of this always_comb gets a default before the case;
   // without it, any path that skips an assignment would infer a latch.
   always_comb begin
      bus_req  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      address  = '0;
      data     = '0;
      tick     = 1'b0;

      case (state)
         REQ: begin
            bus_req = 1'b1;
         end

         RD: begin
            bus_req = 1'b1;
            address = currentTimeAddr;
            MemRead = bus_gnt;
         end

         ARM: begin
            bus_req  = 1'b1;
            address  = currentTimeAddr;
            data     = now_q + period_q;    // wraps modulo 2^width
            MemWrite = bus_gnt;
         end

         ACK: begin
            bus_req  = 1'b1;
            address  = acknowledgeInterruptAddr;
            data     = '0;
            MemWrite = bus_gnt;
         end

         DONE: begin
            tick = do_ack;
         end

         default: begin
            bus_req = 1'b0;
         end
      endcase
   end

   assign busy = (state != IDLE);

`ifdef TICK_MASTER_COUNT_EN
   // ---------------------------------------------------------------------------
   // Tick statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         tick_count <= '0;
         overrun    <= 1'b0;
      end else if (start_accept) begin
         tick_count <= '0;
         overrun    <= 1'b0;
      end else begin
         if (tick) begin
            tick_count <= tick_count + 1'b1;
         end
         // The ACK write has landed by DONE, so a still-high interrupt means
         // the acknowledge was lost.
         if ((state == DONE) && do_ack && TimerInterrupt) begin
            overrun <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_timer_tick_master.sv
// -----------------------------------------------------------------------------
// tb_timer_tick_master
//
// Directed bench for timer_tick_master. Inputs change 1 time unit after the
// rising edge; outputs are compared a further unit later, well away from the
// next edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_timer_tick_master;

   localparam logic [31:0] TIME_ADDR = 32'hFFFF001C;
   localparam logic [31:0] ACK_ADDR  = 32'hFFFF006C;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic [31:0] period;
   logic        TimerInterrupt;
   logic        bus_gnt;
   logic [31:0] rdata;
   logic        bus_req;
   logic [31:0] address;
   logic [31:0] data;
   logic        MemRead;
   logic        MemWrite;
   logic        tick;
   logic        running;
   logic        busy;
`ifdef TICK_MASTER_COUNT_EN
   logic [31:0] tick_count;
   logic        overrun;
`endif

   int checks = 0;
   int errors = 0;
   int tick_seen = 0;

   timer_tick_master dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .period         (period),
      .TimerInterrupt (TimerInterrupt),
      .bus_gnt        (bus_gnt),
      .rdata          (rdata),
      .bus_req        (bus_req),
      .address        (address),
      .data           (data),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .tick           (tick),
      .running        (running),
      .busy           (busy)
`ifdef TICK_MASTER_COUNT_EN
      ,
      .tick_count     (tick_count),
      .overrun        (overrun)
`endif
   );

   always #5 clock = ~clock;

   // Independent count of tick pulses, sampled mid-cycle.
   always @(negedge clock) begin
      if (tick === 1'b1) tick_seen++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Entered in the cycle where the DUT has just moved to REQ with grant high.
   // Walks REQ, RD, ARM, [ACK], DONE, IDLE and checks each bus step.
   task automatic expect_seq(input string name, input logic [31:0] rd,
                             input logic [31:0] deadline, input logic with_ack);
      #1;
      check({name, "_req"},      32'(bus_req), 32'd1);
      check({name, "_req_busy"}, 32'(busy),    32'd1);
      step();
      rdata = rd;
      #1;
      check({name, "_rd_strobe"}, 32'(MemRead), 32'd1);
      check({name, "_rd_addr"},   address,      TIME_ADDR);
      step();
      #1;
      check({name, "_arm_strobe"}, 32'(MemWrite), 32'd1);
      check({name, "_arm_addr"},   address,       TIME_ADDR);
      check({name, "_arm_data"},   data,          deadline);
      check({name, "_arm_tick"},   32'(tick),     32'd0);
      if (with_ack) begin
         step();
         #1;
         check({name, "_ack_strobe"}, 32'(MemWrite), 32'd1);
         check({name, "_ack_addr"},   address,       ACK_ADDR);
         check({name, "_ack_data"},   data,          32'd0);
      end
      step();
      TimerInterrupt = 1'b0;   // timer clears its IRQ after the ACK write
      #1;
      check({name, "_done_tick"}, 32'(tick),     32'(with_ack));
      check({name, "_done_wr"},   32'(MemWrite), 32'd0);
      check({name, "_done_req"},  32'(bus_req),  32'd0);
      step();
      #1;
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_tick"}, 32'(tick), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      stop           = 1'b0;
      period         = '0;
      TimerInterrupt = 1'b0;
      bus_gnt        = 1'b0;
      rdata          = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state held for 3 cycles with all inputs low.
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rst_flags", 32'({bus_req, MemRead, MemWrite, tick, running, busy}), 32'd0);
         check("rst_addr",  address, 32'd0);
         check("rst_data",  data,    32'd0);
`ifdef TICK_MASTER_COUNT_EN
         check("rst_count",   tick_count,    32'd0);
         check("rst_overrun", 32'(overrun),  32'd0);
`endif
         step();
      end

      // Start: period 10, now 100 -> deadline 110, no ACK, no tick.
      bus_gnt   = 1'b1;
      period    = 32'd10;
      start     = 1'b1;
      tick_seen = 0;
      step();
      start = 1'b0;
      expect_seq("start", 32'd100, 32'd110, 1'b0);
      check("start_running", 32'(running), 32'd1);
      check("start_ticks",   32'(tick_seen), 32'd0);

      // Serviced interrupt: now 200 -> deadline 210, ACK, tick 5 cycles later.
      TimerInterrupt = 1'b1;
      tick_seen      = 0;
      #1;
      check("irq_idle_busy", 32'(busy), 32'd0);
      step();
      expect_seq("irq", 32'd200, 32'd210, 1'b1);
      check("irq_ticks", 32'(tick_seen), 32'd1);

      // Period 0 clamps to 2; 0xFFFFFFFF + 2 wraps to 1.
      period = 32'd0;
      start  = 1'b1;
      step();
      start  = 1'b0;
      period = 32'd10;
      expect_seq("clamp", 32'hFFFFFFFF, 32'h00000001, 1'b0);
`ifdef TICK_MASTER_COUNT_EN
      check("clamp_count", tick_count, 32'd0);
`endif

      // Grant lost for 3 cycles in ARM: write held off, then issued once.
      TimerInterrupt = 1'b1;
      tick_seen      = 0;
      step();                       // REQ
      step();                       // RD
      rdata = 32'd50;
      step();                       // ARM
      bus_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("gnt_lost_wr",  32'(MemWrite), 32'd0);
         check("gnt_lost_req", 32'(bus_req),  32'd1);
         step();
      end
      bus_gnt = 1'b1;
      #1;
      check("gnt_back_wr",   32'(MemWrite), 32'd1);
      check("gnt_back_data", data,          32'd52);
      step();                       // ACK
      #1;
      check("gnt_ack_addr", address, ACK_ADDR);
      step();                       // DONE
      TimerInterrupt = 1'b0;
      #1;
      check("gnt_tick", 32'(tick), 32'd1);
      step();
      #1;
      check("gnt_ticks", 32'(tick_seen), 32'd1);

      // Fresh start, then stop during RD of a serviced interrupt.
      period = 32'd10;
      start  = 1'b1;
      step();
      start = 1'b0;
      expect_seq("restart", 32'd0, 32'd10, 1'b0);
      TimerInterrupt = 1'b1;
      step();                       // REQ
      step();                       // RD
      stop  = 1'b1;
      rdata = 32'd300;
      #1;
      check("stop_rd", 32'(MemRead), 32'd1);
      step();                       // ARM
      stop = 1'b0;
      #1;
      check("stop_running",  32'(running),  32'd0);
      check("stop_arm_wr",   32'(MemWrite), 32'd1);
      check("stop_arm_data", data,          32'd310);
      step();                       // ACK
      #1;
      check("stop_ack_wr",   32'(MemWrite), 32'd1);
      check("stop_ack_addr", address,       ACK_ADDR);
      step();                       // DONE
      TimerInterrupt = 1'b0;
      #1;
      check("stop_tick", 32'(tick), 32'd1);
      step();                       // IDLE
      TimerInterrupt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stop_idle_busy", 32'(busy), 32'd0);
         step();
      end
      TimerInterrupt = 1'b0;
`ifdef TICK_MASTER_COUNT_EN
      check("stop_count",   tick_count,   32'd1);
      check("stop_overrun", 32'(overrun), 32'd0);
`endif

      // start and stop together in IDLE: start wins.
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      #1;
      check("startstop_running", 32'(running), 32'd1);
      expect_seq("startstop", 32'd5, 32'd15, 1'b0);

      // Reset in the middle of a sequence returns to IDLE in one cycle.
      TimerInterrupt = 1'b1;
      step();                       // REQ
      step();                       // RD
      rdata = 32'd7;
      reset = 1'b1;
      step();
      reset          = 1'b0;
      TimerInterrupt = 1'b0;
      #1;
      check("midrst_busy",    32'(busy),    32'd0);
      check("midrst_rd",      32'(MemRead), 32'd0);
      check("midrst_req",     32'(bus_req), 32'd0);
      check("midrst_running", 32'(running), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
